wrr_req_queue: RTL
==================

Name: wrr_req_queue

Overview:
- Upstream/downstream companion to the weighted round-robin arbiter.
- Holds one small FIFO per requester and drives the arbiter's request vector from FIFO non-empty status.
- Consumes the arbiter's one-hot grant: pops the granted FIFO and registers the popped word into a single valid/ready output stage for the shared downstream consumer.

Parameters:
- N, 4, number of requesters; must match the arbiter's N.
- DW, 8, data width per requester.
- DEPTH, 4, entries per requester FIFO; power of two, at least 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  N  per-requester push strobe.
- in_data  input  N*DW  per-requester write data; requester i uses bits [i*DW +: DW].
- in_ready  output  N  per-requester FIFO not full.
- request  output  N  to arbiter; FIFO i non-empty AND output stage can accept.
- grant  input  N  from arbiter; expected one-hot or zero.
- out_valid  output  1  output register holds a word.
- out_data  output  DW  popped word.
- out_src  output  clog2(N)  index of the requester that supplied out_data.
- out_ready  input  1  downstream accepts the word.
- grant_err  output  1  sticky flag: illegal grant seen.

Behaviour:
- Reset: all FIFOs empty, pointers 0, out_valid=0, out_data=0, out_src=0, grant_err=0.
  - request=0.
  - in_ready=0 while reset is high; in_ready=all-ones in the first cycle after release.
  - Reset asserted mid-operation discards all FIFO contents and any pending output word.
- FIFO i (pointers wrap modulo DEPTH, count 0..DEPTH):
  - in_ready[i] = (count_i != DEPTH) and not reset.
  - Push when in_valid[i] & in_ready[i].
  - Full blocks a push even if a pop occurs in the same cycle; there is no bypass.
  - Simultaneous push and pop on a non-full FIFO: count unchanged, both pointers advance.
- Output stage accept: can_accept = !out_valid | out_ready.
- Request: request[i] = (count_i != 0) & can_accept. Combinational from registered state plus out_ready.
- Pop: FIFO i pops when grant[i] & request[i].
  - Next cycle: out_valid=1, out_data=head of FIFO i, out_src=i.
  - Grant-to-data latency is 1 cycle.
- Grant holding: the arbiter holds grant for up to weight cycles. Each such cycle with request[i] high pops one word, so the requester streams back-to-back at 1 word/cycle while out_ready=1.
- Output handshake:
  - out_valid & out_ready with no new pop: out_valid falls to 0 next cycle.
  - Output handshake and a new pop in the same cycle: register reloads; out_valid stays 1.
  - out_valid & !out_ready: out_data and out_src hold stable; request is forced to 0, so no pop occurs.
- Grant to a requester whose request is 0 (empty FIFO or stalled output): ignored; no pop, no error.
- Illegal grant: more than one bit set in grant, together with any request overlap.
  - Pop only the lowest-index bit where grant & request.
  - Set grant_err; it stays 1 until reset.
- Grant of all zeros: no pop.
- Push and pop on the same FIFO when it is empty: the pushed word is not visible to request until the next cycle. A push at cycle t makes request visible at t+1, since the push itself only changes count at the edge.
- Ordering: per-requester data leaves in FIFO order; no reordering within a source.

Test Plan:
- Reset, then push 0x11 to req0 at cycle 1 -> request=0001 at cycle 2. Grant=0001 at cycle 2 with out_ready=1 -> out_valid=1, out_data=0x11, out_src=0 at cycle 3. request=0000 afterwards.
- Fill req2 with 4 words (DEPTH=4) -> in_ready[2]=0. A further in_valid[2] is dropped. Grant=0100 held 4 cycles with out_ready=1 -> 4 consecutive outputs in push order, out_src=2. in_ready[2]=1 after the first pop.
- Output stall: out_valid=1 and out_ready=0 for 3 cycles with req1 non-empty and grant=0010 -> request=0000, out_data stable, no pop. Raise out_ready -> the next req1 word appears the following cycle.
- Grant=0110 with req1 and req2 both non-empty -> only req1 pops, out_src=1, grant_err=1 and it stays 1 until reset.
- Grant=1000 with req3 empty -> no pop, out_valid unchanged, grant_err unchanged.
- Reset asserted with 3 words queued on req0 and out_valid=1 -> next cycle out_valid=0, request=0000, in_ready=0. After release, in_ready=1111 and the old data never appears.

Source files
------------

// File: rtl/wrr_req_queue_if.sv
// Handshake bundle between the per-requester queues, the WRR arbiter and the
// shared downstream consumer. The slave modport is the queue block's view.
interface wrr_req_queue_if #(
  parameter int N  = 4,
  parameter int DW = 8
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic [N-1:0]    request;
  logic [N-1:0]    grant;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_src;
  logic            out_ready;
  logic            grant_err;

  modport slave (
    input  in_valid, in_data, grant, out_ready,
    output in_ready, request, out_valid, out_data, out_src, grant_err
  );

  modport master (
    output in_valid, in_data, grant, out_ready,
    input  in_ready, request, out_valid, out_data, out_src, grant_err
  );
endinterface

// File: rtl/wrr_req_queue.sv
// Per-requester FIFOs feeding a WRR arbiter; the granted FIFO is popped into a
// single registered valid/ready output stage shared by all requesters.
module wrr_req_queue #(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  wrr_req_queue_if.slave   bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q    [N][DEPTH];
  logic [DW-1:0] mem_d    [N][DEPTH];
  logic [PW-1:0] wr_ptr_q [N];
  logic [PW-1:0] wr_ptr_d [N];
  logic [PW-1:0] rd_ptr_q [N];
  logic [PW-1:0] rd_ptr_d [N];
  logic [CW-1:0] count_q  [N];
  logic [CW-1:0] count_d  [N];

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q,  out_data_d;
  logic [SW-1:0] out_src_q,   out_src_d;
  logic          grant_err_q, grant_err_d;

  logic          can_accept;
  logic [N-1:0]  rdy;
  logic [N-1:0]  req;
  logic [N-1:0]  hit;
  logic [N-1:0]  push;
  logic [N-1:0]  pop;
  logic          pop_any;
  logic [SW-1:0] pop_idx;

  always_comb begin
    can_accept = !out_valid_q || bus.out_ready;
    rdy        = '0;
    req        = '0;
    for (int unsigned i = 0; i < N; i++) begin
      rdy[i] = (count_q[i] != CW'(DEPTH)) && !reset;
      req[i] = (count_q[i] != '0) && can_accept;
    end
    hit  = bus.grant & req;
    push = bus.in_valid & rdy;
    // Lowest-index hit wins, so an illegal multi-hot grant still pops one word.
    pop     = '0;
    pop_any = 1'b0;
    pop_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (hit[i] && !pop_any) begin
        pop_any = 1'b1;
        pop_idx = SW'(i);
        pop[i]  = 1'b1;
      end
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = bus.in_data[i*DW +: DW];
        wr_ptr_d[i]           = wr_ptr_q[i] + 1'b1;
      end
      if (pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
      end
      case ({push[i], pop[i]})
        2'b10:   count_d[i] = count_q[i] + 1'b1;
        2'b01:   count_d[i] = count_q[i] - 1'b1;
        default: count_d[i] = count_q[i];
      endcase
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (pop_any) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_q[pop_idx][rd_ptr_q[pop_idx]];
      out_src_d   = pop_idx;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    grant_err_d = grant_err_q || (($countones(bus.grant) > 1) && (hit != '0));
  end

  // Storage needs no reset: empty counts make stale entries unreachable.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      grant_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      grant_err_q <= grant_err_d;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.request   = req;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.grant_err = grant_err_q;
endmodule
